// File: rtl/img_stream_tx.sv
// Raster stream transmitter: regenerates vsync/hsync/valid/data from a FIFO-style pixel source.
// Optional internal (x+y) test pattern is built only when IMG_TX_PATTERN_EN is defined.
module img_stream_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int H_SYNC     = 40,
    parameter int H_BACK     = 220,
    parameter int H_DISP     = 1280,
    parameter int H_FRONT    = 110,
    parameter int H_TOTAL    = 1650,
    parameter int V_SYNC     = 5,
    parameter int V_BACK     = 20,
    parameter int V_DISP     = 720,
    parameter int V_FRONT    = 5,
    parameter int V_TOTAL    = 750
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  pattern_en,
    input  logic                  src_empty,
    output logic                  src_rd_en,
    input  logic [DATA_WIDTH-1:0] src_rd_data,
    output logic                  post_img_vsync,
    output logic                  post_img_hsync,
    output logic                  post_img_valid,
    output logic [DATA_WIDTH-1:0] post_img_data,
    output logic                  underflow,
    output logic [15:0]           frame_cnt
);

    localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BACK + H_DISP);
    localparam logic [HW-1:0] H_LAST     = HW'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BACK + V_DISP);
    localparam logic [VW-1:0] V_LAST     = VW'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [HW-1:0]         r_h_cnt;
    logic [VW-1:0]         r_v_cnt;
    logic                  r_vsync;
    logic                  r_hsync;
    logic                  r_valid;
    logic                  r_rd_d;
    logic                  r_underflow;
    logic [15:0]           r_frame_cnt;

    logic                  w_run;
    logic                  w_h_last;
    logic                  w_v_last;
    logic                  w_frame_end;
    logic                  w_frame_start;
    logic                  w_hs;
    logic                  w_vs;
    logic                  w_h_act;
    logic                  w_v_act;
    logic                  w_act;
    logic                  w_starve;
    logic                  w_pat_mode;
    logic [DATA_WIDTH-1:0] w_pat_px;

    assign w_run       = (r_state == S_RUN);
    assign w_h_last    = (r_h_cnt == H_LAST);
    assign w_v_last    = (r_v_cnt == V_LAST);
    assign w_frame_end = w_run & w_h_last & w_v_last;
    assign w_hs        = w_run & (r_h_cnt < H_SYNC_END);
    assign w_vs        = w_run & (r_v_cnt < V_SYNC_END);
    assign w_h_act     = (r_h_cnt >= H_ACT_BEG) & (r_h_cnt < H_ACT_END);
    assign w_v_act     = (r_v_cnt >= V_ACT_BEG) & (r_v_cnt < V_ACT_END);
    assign w_act       = w_run & w_h_act & w_v_act;
    assign w_starve    = w_act & src_empty & ~w_pat_mode;
    assign src_rd_en   = w_act & ~src_empty & ~w_pat_mode & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // tx_en only matters at frame boundaries; mid-frame deassertion lets the frame finish
    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tx_en) begin
                    w_state_nxt   = S_RUN;
                    w_frame_start = 1'b1;
                end
            end
            S_RUN: begin
                if (w_frame_end) begin
                    if (tx_en) begin
                        w_frame_start = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_run) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync     <= 1'b0;
            r_hsync     <= 1'b0;
            r_valid     <= 1'b0;
            r_rd_d      <= 1'b0;
            r_underflow <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_vsync <= w_vs;
            r_hsync <= w_hs;
            r_valid <= w_act;
            r_rd_d  <= src_rd_en;
            if (w_frame_start) begin
                r_underflow <= 1'b0;
            end else if (w_starve) begin
                r_underflow <= 1'b1;
            end
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

`ifdef IMG_TX_PATTERN_EN
    logic                  r_pat_mode;
    logic [DATA_WIDTH-1:0] r_x;
    logic [DATA_WIDTH-1:0] r_y;
    logic [DATA_WIDTH-1:0] r_pat_px;

    // coordinates are kept modulo 2^DATA_WIDTH, which is all the pattern sum needs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat_mode <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_pat_px   <= '0;
        end else begin
            if (w_frame_start) begin
                r_pat_mode <= pattern_en;
            end
            if (!w_run || w_h_last) begin
                r_x <= '0;
            end else if (w_act) begin
                r_x <= r_x + 1'b1;
            end
            if (!w_run || w_frame_end) begin
                r_y <= '0;
            end else if (w_h_last && w_v_act) begin
                r_y <= r_y + 1'b1;
            end
            r_pat_px <= (w_act && r_pat_mode) ? r_x + r_y : '0;
        end
    end

    assign w_pat_mode = r_pat_mode;
    assign w_pat_px   = r_pat_px;
`else
    logic w_unused_pattern_en;

    assign w_unused_pattern_en = pattern_en;
    assign w_pat_mode          = 1'b0;
    assign w_pat_px            = '0;
`endif

    assign post_img_vsync = r_vsync;
    assign post_img_hsync = r_hsync;
    assign post_img_valid = r_valid;
    assign post_img_data  = r_rd_d ? src_rd_data : w_pat_px;
    assign underflow      = r_underflow;
    assign frame_cnt      = r_frame_cnt;

endmodule

// File: tb/tb_img_stream_tx.sv
// Directed bench for img_stream_tx on a 15x8 raster (120-cycle frame) with a counting source model.
module tb_img_stream_tx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_en;
    logic          pattern_en;
    logic          src_empty;
    logic          src_rd_en;
    logic [DW-1:0] src_rd_data = '0;
    logic          post_img_vsync;
    logic          post_img_hsync;
    logic          post_img_valid;
    logic [DW-1:0] post_img_data;
    logic          underflow;
    logic [15:0]   frame_cnt;

    int total = 0;
    int bad   = 0;

    int   e_idx      = 0;
    int   exp_frames = 0;
    logic u_exp      = 1'b0;
    logic pat_exp    = 1'b0;

    logic [DW-1:0] src_idx = '0;

    always #5 clk = ~clk;

    img_stream_tx #(
        .DATA_WIDTH(DW),
        .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2), .H_TOTAL(15),
        .V_SYNC(1), .V_BACK(2), .V_DISP(4), .V_FRONT(1), .V_TOTAL(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_en         (tx_en),
        .pattern_en    (pattern_en),
        .src_empty     (src_empty),
        .src_rd_en     (src_rd_en),
        .src_rd_data   (src_rd_data),
        .post_img_vsync(post_img_vsync),
        .post_img_hsync(post_img_hsync),
        .post_img_valid(post_img_valid),
        .post_img_data (post_img_data),
        .underflow     (underflow),
        .frame_cnt     (frame_cnt)
    );

    // source model: each read returns the running read index one cycle later
    always @(posedge clk) begin
        if (src_rd_en) begin
            src_rd_data <= src_idx;
            src_idx     <= src_idx + 8'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check(tag, 32'({post_img_vsync, post_img_hsync, post_img_valid, post_img_data}), 32'd0);
        check({tag, "_rd"}, 32'(src_rd_en), 32'd0);
    endtask

    // Entered with the counters at (0,0); n indexes the counter cycle whose decode is checked.
    task automatic run_frame(input int starve_v, input int sh0, input int sh1,
                             input int stop_n, input int rst_n);
        int            h;
        int            v;
        logic          act;
        logic          empty;
        logic          rd;
        logic [DW-1:0] d_exp;
        for (int n = 0; n < 120; n++) begin
            h     = n % 15;
            v     = n / 15;
            act   = (h >= 5) && (h < 13) && (v >= 3) && (v < 7);
            empty = (v == starve_v) && (h >= sh0) && (h <= sh1);
            src_empty = empty;
            if (n == stop_n) tx_en = 1'b0;
            if (n == rst_n) begin
                rst = 1'b1;
                #1;
                check("rd_in_rst", 32'(src_rd_en), 32'd0);
                tick;
                check("rst_mid_out", 32'({post_img_vsync, post_img_hsync, post_img_valid,
                                          post_img_data, underflow}), 32'd0);
                check("rst_mid_fcnt", 32'(frame_cnt), 32'd0);
                rst        = 1'b0;
                src_empty  = 1'b0;
                exp_frames = 0;
                u_exp      = 1'b0;
                return;
            end
            rd = act && !empty && !pat_exp;
            #1;
            check("rd_en", 32'(src_rd_en), 32'(rd));
            if (!act)         d_exp = '0;
            else if (pat_exp) d_exp = 8'(h + v - 8);
            else if (empty)   d_exp = '0;
            else              d_exp = 8'(e_idx);
            if (rd) e_idx++;
            tick;
            check("sync", 32'({post_img_vsync, post_img_hsync, post_img_valid}),
                  32'({(v < 1), (h < 2), act}));
            check("data", 32'(post_img_data), 32'(d_exp));
            if (n == 119 && tx_en)             u_exp = 1'b0;
            else if (act && empty && !pat_exp) u_exp = 1'b1;
            check("uflow", 32'(underflow), 32'(u_exp));
        end
        exp_frames++;
        check("fcnt", 32'(frame_cnt), 32'(exp_frames));
    endtask

    initial begin
        rst        = 1'b1;
        tx_en      = 1'b0;
        pattern_en = 1'b0;
        src_empty  = 1'b0;
        tick;
        tick;
        check_quiet("rst_out");
        check("rst_fcnt", 32'(frame_cnt), 32'd0);
        check("rst_uflow", 32'(underflow), 32'd0);

        rst = 1'b0;
        tick;
        check_quiet("idle_out");

        // nominal frame, then a starved frame, then a frame stopped at a boundary
        tx_en = 1'b1;
        tick;
        check_quiet("start_out");
        run_frame(-1, 0, -1, -1, -1);
        check("nom_reads", 32'(src_idx), 32'd32);
        run_frame(4, 7, 9, -1, -1);
        check("starve_reads", 32'(src_idx), 32'd61);
        run_frame(-1, 0, -1, 50, -1);
        check("stop_reads", 32'(src_idx), 32'd93);
        for (int i = 0; i < 3; i++) begin
            tick;
            check_quiet("stop_idle");
            check("stop_fcnt", 32'(frame_cnt), 32'd3);
        end

        // restart, reset during an active pixel, then a full frame (pattern_en raised)
        tx_en = 1'b1;
        tick;
        u_exp = 1'b0;
        run_frame(-1, 0, -1, -1, 51);
        pattern_en = 1'b1;
`ifdef IMG_TX_PATTERN_EN
        pat_exp = 1'b1;
`else
        pat_exp = 1'b0;
`endif
        tick;
        check_quiet("restart_out");
        run_frame(-1, 0, -1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/img_stream_tx.md
# img_stream_tx

Video-stream transmitter. Regenerates the `vsync`/`hsync`/`valid`/`data` raster stream consumed by the window-based filters (sobel, sharpen, 3x3 window generator), from a pixel buffer with FIFO-style read semantics. It sits between a frame/line buffer (DDR read FIFO or BRAM) and the `pre_img_*` inputs of the processing chain. Timing is fully parameterised with the same raster parameters the filters use.

## Interface
- `DATA_WIDTH`, 8, pixel width
- `H_SYNC` / `H_BACK` / `H_DISP` / `H_FRONT` / `H_TOTAL`, 40 / 220 / 1280 / 110 / 1650, horizontal timing in clocks. `H_TOTAL` = sum of the other four.
- `V_SYNC` / `V_BACK` / `V_DISP` / `V_FRONT` / `V_TOTAL`, 5 / 20 / 720 / 5 / 750, vertical timing in lines. `V_TOTAL` = sum of the other four.
- `clk`  in  1  pixel clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `tx_en`  in  1  start/continue transmission; sampled at frame boundaries
- `pattern_en`  in  1  select internal test pattern (see Configuration)
- `src_empty`  in  1  pixel source empty
- `src_rd_en`  out  1  source read strobe (combinational)
- `src_rd_data`  in  DATA_WIDTH  source data, valid 1 cycle after `src_rd_en`
- `post_img_vsync`  out  1  frame sync, active high
- `post_img_hsync`  out  1  line sync, active high
- `post_img_valid`  out  1  active-pixel qualifier
- `post_img_data`  out  DATA_WIDTH  pixel; 0 when `post_img_valid`=0
- `underflow`  out  1  sticky per frame: a pixel was starved in the current frame
- `frame_cnt`  out  16  completed frames, wraps at 65535→0

## Operation
- **State machine:**
  - IDLE: `h_cnt` = `v_cnt` = 0; all `post_img_*` are 0. Moves to RUN on the first cycle with `tx_en`=1.
  - RUN: counters advance.
  - End of frame is `h_cnt`=H_TOTAL-1 and `v_cnt`=V_TOTAL-1. At end of frame, `frame_cnt` increments. The block then wraps to (0,0) if `tx_en`=1, otherwise returns to IDLE.
  - Deasserting `tx_en` mid-frame never truncates the frame.
- **Counters:**
  - `h_cnt` runs 0..H_TOTAL-1.
  - `v_cnt` increments when `h_cnt` wraps, and runs 0..V_TOTAL-1.
- **Decode (in RUN):**
  - hs = `h_cnt` < H_SYNC
  - vs = `v_cnt` < V_SYNC
  - act = `h_cnt` ∈ [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and `v_cnt` ∈ [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP)
- **Read:**
  - `src_rd_en` = RUN & act & ~`src_empty` & ~pattern mode.
  - The block never reads while `src_empty`=1.
- **Starvation:** act=1 with `src_empty`=1 (pattern mode off) is a starved pixel. The output still shows `post_img_valid`=1 with data 0, and `underflow` sets.
- **Underflow clear:** `underflow` clears on IDLE→RUN and at every frame wrap. A starved pixel in the frame's cycle (0,0) is impossible, so the clear and a set never coincide.
- **Raster integrity:** the raster is never stalled. Timing is preserved over data integrity.
- **Active coordinates:** x = 0..H_DISP-1 and y = 0..V_DISP-1 are tracked for pattern mode.

## Timing
- Decode at counter cycle t appears on `post_img_*` at t+1 (registered). It is aligned with `src_rd_data` for a read issued at t.
- `src_rd_en` has zero latency from the counters.
- Start-up: `tx_en` rises at cycle 0 → RUN at 1 with (0,0) → first `post_img_vsync`/`post_img_hsync`=1 at cycle 2.
- **Reset values:** all outputs 0, `frame_cnt`=0, `underflow`=0, state IDLE.
- **Reset mid-frame:** the next edge forces the reset values and drops any read in flight. `src_rd_en` is 0 while `rst`=1.
- **Frame and line rates:** one pixel per clock; frame period exactly H_TOTAL×V_TOTAL clocks; H_DISP×V_DISP valid cycles per frame.

## Configuration
- `IMG_TX_PATTERN_EN` defined:
  - `pattern_en`=1 (sampled per frame at wrap or IDLE→RUN) sources pixels internally: data = (x + y) mod 2^DATA_WIDTH.
  - `src_rd_en` stays 0 and `underflow` never sets.
- Undefined: `pattern_en` is ignored and pattern logic is not synthesised.

## Test plan
Benches use small timing: H = 2/3/8/2/15, V = 1/2/4/1/8 (120-cycle frame).
- **Nominal frame:** `tx_en`=1, source never empty, data = read index → exactly 32 valid cycles; values 0..31 in order; hsync high 2 of every 15 cycles; vsync high for 15 cycles; `frame_cnt`=1 after 120 cycles.
- **Starvation:** `src_empty`=1 for 3 cycles during the 2nd active line → `post_img_valid` stays on all 8 cycles of that line; 3 zero pixels; no `src_rd_en` while empty; `underflow`=1 until the next frame wrap clears it.
- **Stop at boundary:** `tx_en` dropped at `h_cnt`=5, `v_cnt`=3 → frame completes; IDLE at cycle 120; all outputs 0; `frame_cnt`=1.
- **Mid-frame reset:** `rst` pulsed for 1 cycle during an active pixel → all outputs 0 the next cycle; `frame_cnt`=0; restart produces a full frame with vsync first.
- **Pattern mode:** with `IMG_TX_PATTERN_EN` defined and `pattern_en`=1 → pixel (x=7, y=3) = 10; `src_rd_en` never asserted.
- **Pattern disabled:** without the macro and `pattern_en`=1 → identical to the nominal frame.
